// File: rtl/iterator_table_mem_if.sv
// Request/response bundle between the SIMD iterator address generator (master)
// and the per-namespace iterator table (slave).
interface iterator_table_mem_if #(
   parameter int unsigned NS_INDEX_ID_BITS  = 5,
   parameter int unsigned NS_ID_BITS        = 3,
   parameter int unsigned BASE_STRIDE_WIDTH = 4 * (NS_INDEX_ID_BITS + NS_ID_BITS)
);
   logic                          init_req;
   logic                          busy;
   logic                          rd_req;
   logic [NS_INDEX_ID_BITS-1:0]   rd_addr;
   logic                          rd_valid;
   logic [BASE_STRIDE_WIDTH-1:0]  rd_base;
   logic [BASE_STRIDE_WIDTH-1:0]  rd_stride;
   logic                          wr_req_base;
   logic [NS_INDEX_ID_BITS-1:0]   wr_addr_base;
   logic [BASE_STRIDE_WIDTH-1:0]  wr_data_base;
   logic                          wr_req_stride;
   logic [NS_INDEX_ID_BITS-1:0]   wr_addr_stride;
   logic [BASE_STRIDE_WIDTH-1:0]  wr_data_stride;
   logic                          wr_drop;

   modport master (
      output init_req, rd_req, rd_addr,
             wr_req_base, wr_addr_base, wr_data_base,
             wr_req_stride, wr_addr_stride, wr_data_stride,
      input  busy, rd_valid, rd_base, rd_stride, wr_drop
   );

   modport slave (
      input  init_req, rd_req, rd_addr,
             wr_req_base, wr_addr_base, wr_data_base,
             wr_req_stride, wr_addr_stride, wr_data_stride,
      output busy, rd_valid, rd_base, rd_stride, wr_drop
   );
endinterface

// File: rtl/iterator_table_mem.sv
// Per-namespace base/stride table with a zeroing sweep after reset or init_req.
// ITER_TABLE_WR_FWD_EN: defined = write-first on read/write collision, undefined = read-first.
module iterator_table_mem #(
   parameter int unsigned NS_INDEX_ID_BITS  = 5,
   parameter int unsigned NS_ID_BITS        = 3,
   parameter int unsigned BASE_STRIDE_WIDTH = 4 * (NS_INDEX_ID_BITS + NS_ID_BITS)
) (
   input  logic               clk,
   input  logic               reset_n,
   iterator_table_mem_if.slave bus
);
   localparam int unsigned IW    = NS_INDEX_ID_BITS;
   localparam int unsigned W     = BASE_STRIDE_WIDTH;
   localparam int unsigned DEPTH = 1 << NS_INDEX_ID_BITS;
   localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

   typedef enum logic {CLEAR = 1'b0, IDLE = 1'b1} state_t;

   state_t          state, state_nxt;
   logic [IW-1:0]   cnt, cnt_nxt;
   logic            busy_q, wr_drop_q, rd_valid_q;
   logic [W-1:0]    rd_base_q, rd_stride_q;

   logic            init_go_c, drop_c;
   logic            base_we_c, stride_we_c;
   logic [IW-1:0]   base_wa_c, stride_wa_c;
   logic [W-1:0]    base_wd_c, stride_wd_c;
   logic [W-1:0]    rd_base_c, rd_stride_c;

   logic [W-1:0]    base_mem   [DEPTH];
   logic [W-1:0]    stride_mem [DEPTH];

   // Next state and the single write port of each bank (sweep or host write).
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      init_go_c   = 1'b0;
      base_we_c   = 1'b0;
      stride_we_c = 1'b0;
      base_wa_c   = bus.wr_addr_base;
      stride_wa_c = bus.wr_addr_stride;
      base_wd_c   = bus.wr_data_base;
      stride_wd_c = bus.wr_data_stride;
      drop_c      = 1'b0;
      unique case (state)
         CLEAR: begin
            base_we_c   = 1'b1;
            stride_we_c = 1'b1;
            base_wa_c   = cnt;
            stride_wa_c = cnt;
            base_wd_c   = '0;
            stride_wd_c = '0;
            cnt_nxt     = cnt + IW'(1);
            if (cnt == LAST) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end
         end
         IDLE: begin
            if (bus.init_req) begin
               init_go_c = 1'b1;
               state_nxt = CLEAR;
               cnt_nxt   = '0;
            end else begin
               base_we_c   = bus.wr_req_base;
               stride_we_c = bus.wr_req_stride;
            end
         end
         default: begin
            state_nxt = CLEAR;
            cnt_nxt   = '0;
         end
      endcase
      drop_c = (bus.wr_req_base | bus.wr_req_stride) & ((state == CLEAR) | init_go_c);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= CLEAR;
         cnt       <= '0;
         busy_q    <= 1'b1;
         wr_drop_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         busy_q    <= (state_nxt == CLEAR);
         wr_drop_q <= drop_c;
      end
   end

   // Table storage is deliberately not reset; the sweep clears it.
   always_ff @(posedge clk) begin
      if (base_we_c)   base_mem[base_wa_c]     <= base_wd_c;
      if (stride_we_c) stride_mem[stride_wa_c] <= stride_wd_c;
   end

`ifdef ITER_TABLE_WR_FWD_EN
   // Write-first: an accepted same-cycle write to the read index wins, per bank.
   always_comb begin
      rd_base_c   = base_mem[bus.rd_addr];
      rd_stride_c = stride_mem[bus.rd_addr];
      if ((state == IDLE) && base_we_c && (base_wa_c == bus.rd_addr))
         rd_base_c = base_wd_c;
      if ((state == IDLE) && stride_we_c && (stride_wa_c == bus.rd_addr))
         rd_stride_c = stride_wd_c;
   end
`else
   always_comb begin
      rd_base_c   = base_mem[bus.rd_addr];
      rd_stride_c = stride_mem[bus.rd_addr];
   end
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_valid_q  <= 1'b0;
         rd_base_q   <= '0;
         rd_stride_q <= '0;
      end else begin
         rd_valid_q <= bus.rd_req;
         if (bus.rd_req) begin
            rd_base_q   <= (state == CLEAR) ? '0 : rd_base_c;
            rd_stride_q <= (state == CLEAR) ? '0 : rd_stride_c;
         end
      end
   end

   assign bus.busy      = busy_q;
   assign bus.wr_drop   = wr_drop_q;
   assign bus.rd_valid  = rd_valid_q;
   assign bus.rd_base   = rd_base_q;
   assign bus.rd_stride = rd_stride_q;
endmodule

// File: tb/tb_iterator_table_mem.sv
// Randomized bench for iterator_table_mem against a table-level reference model.
module tb_iterator_table_mem;
   localparam int unsigned IW    = 5;
   localparam int unsigned W     = 32;
   localparam int unsigned DEPTH = 32;
`ifdef ITER_TABLE_WR_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   iterator_table_mem_if bus ();

   iterator_table_mem dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: table contents plus remaining sweep cycles.
   logic [W-1:0] m_base   [DEPTH];
   logic [W-1:0] m_stride [DEPTH];
   int           sweep_left = DEPTH;
   logic         e_busy = 1'b1, e_valid = 1'b0, e_drop = 1'b0;
   logic [W-1:0] e_base = '0, e_stride = '0;
   bit           sweeping, acc_init, wb_ok, ws_ok;

   always @(posedge clk) begin
      if (!reset_n) begin
         sweep_left = DEPTH;
         for (int i = 0; i < DEPTH; i++) begin m_base[i] = '0; m_stride[i] = '0; end
         e_busy = 1'b1; e_valid = 1'b0; e_drop = 1'b0; e_base = '0; e_stride = '0;
      end else begin
         sweeping = (sweep_left > 0);
         acc_init = !sweeping && bus.init_req;
         wb_ok    = !sweeping && !acc_init && bus.wr_req_base;
         ws_ok    = !sweeping && !acc_init && bus.wr_req_stride;
         e_drop   = (bus.wr_req_base || bus.wr_req_stride) && (sweeping || acc_init);
         e_valid  = bus.rd_req;
         if (bus.rd_req) begin
            if (sweeping) begin
               e_base = '0; e_stride = '0;
            end else begin
               e_base   = (FWD && wb_ok && bus.wr_addr_base == bus.rd_addr)
                          ? bus.wr_data_base : m_base[bus.rd_addr];
               e_stride = (FWD && ws_ok && bus.wr_addr_stride == bus.rd_addr)
                          ? bus.wr_data_stride : m_stride[bus.rd_addr];
            end
         end
         if (sweeping) sweep_left--;
         else if (acc_init) begin
            sweep_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) begin m_base[i] = '0; m_stride[i] = '0; end
         end else begin
            if (wb_ok) m_base[bus.wr_addr_base]     = bus.wr_data_base;
            if (ws_ok) m_stride[bus.wr_addr_stride] = bus.wr_data_stride;
         end
         e_busy = (sweep_left > 0);
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (reset_n) begin
         chk("busy",      W'(bus.busy),     W'(e_busy));
         chk("rd_valid",  W'(bus.rd_valid), W'(e_valid));
         chk("wr_drop",   W'(bus.wr_drop),  W'(e_drop));
         chk("rd_base",   bus.rd_base,      e_base);
         chk("rd_stride", bus.rd_stride,    e_stride);
      end
   end

   task automatic idle_in();
      bus.init_req = 1'b0;       bus.rd_req = 1'b0;         bus.rd_addr = '0;
      bus.wr_req_base = 1'b0;    bus.wr_addr_base = '0;     bus.wr_data_base = '0;
      bus.wr_req_stride = 1'b0;  bus.wr_addr_stride = '0;   bus.wr_data_stride = '0;
   endtask

   task automatic count_busy(output int n);
      n = 0;
      while (bus.busy && n < 100) begin
         n++;
         @(negedge clk);
      end
   endtask

   int n, nb, nd;

   initial begin
      idle_in();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_busy", W'(bus.busy), 32'd1);
      chk("reset_rd_valid", W'(bus.rd_valid), 32'd0);
      reset_n = 1'b1;
      bus.rd_req = 1'b1;
      bus.rd_addr = 5'd7;
      count_busy(n);
      chk("sweep_len_after_reset", W'(n), 32'd32);
      chk("rd_base_after_sweep", bus.rd_base, 32'h0);
      idle_in();

      // Both banks written to the same index in one cycle.
      bus.wr_req_base = 1'b1;   bus.wr_addr_base = 5'd3;   bus.wr_data_base = 32'h10;
      bus.wr_req_stride = 1'b1; bus.wr_addr_stride = 5'd3; bus.wr_data_stride = 32'h4;
      @(negedge clk); idle_in();
      bus.rd_req = 1'b1; bus.rd_addr = 5'd3;
      @(negedge clk); idle_in();
      chk("rd3_valid", W'(bus.rd_valid), 32'd1);
      chk("rd3_base", bus.rd_base, 32'h10);
      chk("rd3_stride", bus.rd_stride, 32'h4);

      // Read colliding with a base write.
      bus.rd_req = 1'b1; bus.rd_addr = 5'd3;
      bus.wr_req_base = 1'b1; bus.wr_addr_base = 5'd3; bus.wr_data_base = 32'h14;
      @(negedge clk); idle_in();
      chk("collide_base", bus.rd_base, FWD ? 32'h14 : 32'h10);
      chk("collide_stride", bus.rd_stride, 32'h4);
      bus.rd_req = 1'b1; bus.rd_addr = 5'd3;
      @(negedge clk); idle_in();
      chk("reread_base", bus.rd_base, 32'h14);

      // init_req together with a write: write dropped, table cleared.
      bus.init_req = 1'b1;
      bus.wr_req_base = 1'b1; bus.wr_addr_base = 5'd5; bus.wr_data_base = 32'hAA;
      @(negedge clk); idle_in();
      chk("init_wr_drop", W'(bus.wr_drop), 32'd1);
      count_busy(n);
      chk("sweep_len_init", W'(n), 32'd32);
      bus.rd_req = 1'b1; bus.rd_addr = 5'd5;
      @(negedge clk); idle_in();
      chk("base5_cleared", bus.rd_base, 32'h0);
      bus.rd_req = 1'b1; bus.rd_addr = 5'd3;
      @(negedge clk); idle_in();
      chk("stride3_cleared", bus.rd_stride, 32'h0);

      // Dropped stride writes and an ignored init_req during the sweep.
      bus.init_req = 1'b1;
      @(negedge clk); idle_in();
      nb = 0; nd = 0;
      for (int i = 0; i < 100; i++) begin
         if (bus.busy) nb++;
         if (bus.wr_drop) nd++;
         if (!bus.busy) break;
         bus.wr_req_stride  = (i >= 4 && i < 7);
         bus.wr_addr_stride = IW'($urandom);
         bus.wr_data_stride = $urandom;
         bus.init_req       = (i == 10);
         @(negedge clk);
      end
      idle_in();
      chk("sweep_len_with_drops", W'(nb), 32'd32);
      chk("drop_pulses", W'(nd), 32'd3);

      // Random traffic with narrow addresses to force collisions.
      for (int i = 0; i < 400; i++) begin
         bus.rd_req         = 1'($urandom_range(0, 1));
         bus.rd_addr        = IW'($urandom_range(0, 7));
         bus.wr_req_base    = ($urandom_range(0, 2) == 0);
         bus.wr_addr_base   = IW'($urandom_range(0, 7));
         bus.wr_data_base   = $urandom;
         bus.wr_req_stride  = ($urandom_range(0, 2) == 0);
         bus.wr_addr_stride = IW'($urandom_range(0, 7));
         bus.wr_data_stride = $urandom;
         bus.init_req       = ($urandom_range(0, 59) == 0);
         @(negedge clk);
      end
      idle_in();
      @(negedge clk);
      count_busy(n);
      chk("random_settle", W'(bus.busy), 32'd0);

      // Reset in the middle of a sweep at cnt=10.
      bus.init_req = 1'b1; bus.rd_req = 1'b1; bus.rd_addr = 5'd2;
      @(negedge clk);
      bus.init_req = 1'b0;
      repeat (9) @(negedge clk);
      bus.wr_req_base = 1'b1;
      @(negedge clk);
      chk("pre_reset_drop", W'(bus.wr_drop), 32'd1);
      chk("pre_reset_valid", W'(bus.rd_valid), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("async_reset_valid", W'(bus.rd_valid), 32'd0);
      chk("async_reset_drop", W'(bus.wr_drop), 32'd0);
      chk("async_reset_busy", W'(bus.busy), 32'd1);
      idle_in();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      count_busy(n);
      chk("sweep_len_after_mid_reset", W'(n), 32'd32);
      bus.rd_req = 1'b1; bus.rd_addr = 5'd3;
      @(negedge clk); idle_in();
      chk("post_reset_read", bus.rd_base, 32'h0);
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1);
   end
endmodule

// File: doc/iterator_table_mem.md
Name: iterator_table_mem

Overview:
- Per-namespace iterator table storage; the responder side of the SIMD iterator address generator.
- Holds base and stride words for each namespace index (default 32 entries).
- Accepts base/stride configuration writes and loop-update base writes from the generator.
- Answers read requests with a one-cycle registered response. Includes an init sweep that zeroes the table after reset or on command.

Parameters:
- NS_INDEX_ID_BITS, 5, index width; table depth = 2**NS_INDEX_ID_BITS.
- NS_ID_BITS, 3, namespace id width (used only for the width default below).
- BASE_STRIDE_WIDTH, 4*(NS_INDEX_ID_BITS+NS_ID_BITS), base/stride word width (default 32).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- init_req  in  1  pulse: start table-zero sweep
- busy  out  1  high while the sweep runs
- rd_req  in  1  read request
- rd_addr  in  NS_INDEX_ID_BITS  read index
- rd_valid  out  1  response valid, one cycle after rd_req
- rd_base  out  BASE_STRIDE_WIDTH  base word at rd_addr
- rd_stride  out  BASE_STRIDE_WIDTH  stride word at rd_addr
- wr_req_base  in  1  base write strobe
- wr_addr_base  in  NS_INDEX_ID_BITS  base write index
- wr_data_base  in  BASE_STRIDE_WIDTH  base write data
- wr_req_stride  in  1  stride write strobe
- wr_addr_stride  in  NS_INDEX_ID_BITS  stride write index
- wr_data_stride  in  BASE_STRIDE_WIDTH  stride write data
- wr_drop  out  1  pulse: a write was discarded (during sweep or init start)

Behaviour:
- Reset values: busy=1, rd_valid=0, rd_base=0, rd_stride=0, wr_drop=0. FSM resets to CLEAR with sweep counter=0.
- Memory arrays are not reset; the sweep zeroes them.
- FSM states: CLEAR and IDLE.
  - CLEAR: each cycle writes 0 to base[cnt] and stride[cnt], then cnt++. When cnt == DEPTH-1 is written, go to IDLE next cycle with busy=0.
  - Sweep length is exactly DEPTH cycles; busy is high for those DEPTH cycles.
  - IDLE: if init_req, go to CLEAR with cnt=0. Otherwise service writes.
  - init_req while in CLEAR is ignored; the sweep does not restart.
- Writes in IDLE take effect at the clock edge. Base and stride banks are independent, so writing both to the same address in the same cycle is legal and both land.
- In the cycle init_req is accepted, any write strobe is dropped. wr_drop=1 on the next cycle.
- Any write strobe during CLEAR is dropped. wr_drop pulses one cycle later for each cycle containing a dropped write.
- Read latency is 1: rd_valid(t+1)=rd_req(t), and rd_base/rd_stride are registered. They hold their last value when rd_req=0.
- Reads during CLEAR return 0 data with rd_valid=1.
- Read/write same address, same cycle, in IDLE: behaviour set by the optional feature below.
- A mid-operation reset asserts asynchronously: outputs go to reset values and a fresh sweep starts on release.

Optional Feature:
- Macro: ITER_TABLE_WR_FWD_EN.
- Defined: write-first. A read colliding with a write to the same address in the same cycle returns the new write data, per bank independently. This supports back-to-back loop base updates (base+stride writeback followed by an immediate reread).
- Undefined: read-first. The colliding read returns the pre-write contents; the new value is visible from the next cycle.

Test Plan:
- Release reset_n; hold rd_req=1, rd_addr=7 -> busy high exactly 32 cycles; rd_base=rd_stride=0 throughout; busy=0 afterwards.
- IDLE: write base[3]=0x0000_0010 and stride[3]=0x0000_0004 in the same cycle; read addr 3 next cycle -> rd_valid=1 one cycle later, rd_base=0x10, rd_stride=0x4.
- Read addr 3 in the same cycle as a base write of 0x14 to addr 3 -> rd_base=0x14 with ITER_TABLE_WR_FWD_EN; 0x10 without it. rd_stride=0x4 in both builds.
- Pulse init_req together with wr_req_base (addr 5, data 0xAA) -> wr_drop=1 next cycle; after the 32-cycle sweep, base[5] reads 0.
- During CLEAR, assert wr_req_stride for 3 consecutive cycles; pulse init_req again mid-sweep -> wr_drop high 3 cycles; total busy duration stays 32 cycles.
- Drop reset_n mid-sweep at cnt=10 -> outputs reset immediately; after release, a full 32-cycle sweep runs again.
